iomem_switch: RTL and testbench
===============================

IOMEM_SWITCH -- requirements
Module: iomem_switch

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of peripheral ports (1..8).
REQ-002 SHALL have parameter BASE_ID, default 8'h03, the addr[31:24] value mapped to slave 0.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum cycles (1..255) to wait for a slave ready.
REQ-004 SHALL have port: clk  in  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: m_valid  in  1  CPU iomem request valid.
REQ-007 SHALL have port: m_ready  out  1  CPU iomem response, a one-cycle pulse.
REQ-008 SHALL have port: m_addr  in  32  request address.
REQ-009 SHALL have port: m_wstrb  in  4  byte write strobes; 0 means read.
REQ-010 SHALL have port: m_wdata  in  32  write data.
REQ-011 SHALL have port: m_rdata  out  32  read data, valid while m_ready is high.
REQ-012 SHALL have port: s_valid  out  NUM_SLAVES  one-hot per-slave request.
REQ-013 SHALL have port: s_addr, s_wstrb, s_wdata  out  32/4/32  shared, registered copies of the latched request.
REQ-014 SHALL have port: s_ready  in  NUM_SLAVES  per-slave completion.
REQ-015 SHALL have port: s_rdata  in  32*NUM_SLAVES  per-slave read data; slave i occupies bits [32i+31:32i].
REQ-016 SHALL have port: err_count  out  8  saturating count of bus errors.
REQ-017 SHALL have port: err_irq  out  1  one-cycle pulse per bus error.

Function
REQ-018 SHALL implement the states IDLE, BUSY, RESP and ERR.
REQ-019 In IDLE with m_valid=1, SHALL latch m_addr, m_wstrb and m_wdata into s_addr, s_wstrb and s_wdata.
REQ-020 Decode (same IDLE cycle): SHALL compute sel = m_addr[31:24] - BASE_ID, 8-bit unsigned.
REQ-021 If sel < NUM_SLAVES, SHALL go to BUSY and set s_valid[sel]=1 from the next cycle; otherwise SHALL go to ERR.
REQ-022 In BUSY, SHALL hold exactly one s_valid bit high and ignore all s_ready bits other than s_ready[sel].
REQ-023 In BUSY with s_ready[sel]=1, SHALL register s_rdata slice sel into m_rdata, clear s_valid, and go to RESP.
REQ-024 In BUSY, a wait counter SHALL start at 0 on BUSY entry and increment each BUSY cycle without s_ready[sel].
REQ-025 When the wait counter reaches TIMEOUT-1 without s_ready[sel], SHALL clear s_valid, load m_rdata=32'hDEAD_BEEF, go to RESP, and flag a bus error.
REQ-026 If s_ready[sel] and the timeout fall in the same cycle, the slave response SHALL win: no error, slave data returned.
REQ-027 In ERR, SHALL load m_rdata=32'hDEAD_BEEF, flag a bus error, and go to RESP.
REQ-028 In RESP, SHALL drive m_ready=1 for exactly one cycle, then return to IDLE.
REQ-029 m_ready SHALL be 0 in every state except RESP.
REQ-030 Minimum latency: m_valid sampled at T, s_valid high at T+1, s_ready at T+1 gives m_ready at T+2.
REQ-031 Decode-error latency: m_valid sampled at T gives m_ready at T+2.
REQ-032 Each bus error SHALL produce err_irq=1 for one cycle, registered, coincident with m_ready.
REQ-033 Each bus error SHALL increment err_count by 1, saturating at 8'hFF.
REQ-034 A write (m_wstrb != 0) SHALL be handled identically to a read; only s_wstrb differs.
REQ-035 m_rdata SHALL hold its value outside RESP.
REQ-036 Changes to m_valid, m_addr or m_wdata outside IDLE SHALL be ignored.
REQ-037 A new request SHALL only be accepted in IDLE; the earliest new acceptance is the cycle after RESP.

Reset
REQ-038 On reset=1 at a clock edge, SHALL force: state IDLE, s_valid=0, m_ready=0, err_irq=0, err_count=0, m_rdata=0, wait counter=0.
REQ-039 On reset=1 at a clock edge, SHALL force s_addr, s_wstrb and s_wdata to 0.
REQ-040 Reset asserted during BUSY or RESP SHALL abandon the transaction: no m_ready pulse and no error counted.
REQ-041 The first request SHALL be accepted in the first cycle with reset=0.

Structure
REQ-042 Package iomem_pkg SHALL hold: IOMEM_ERR_DATA (32'hDEAD_BEEF), IOMEM_BASE_ID (8'h03), the state enumeration, and address/data/strobe width constants.
REQ-043 SHALL be a single module with no sub-modules; the wait counter and decoder are inline.

Verification
REQ-044 Read, slave 0 registered: m_addr=0x0300_0000, s_ready[0] 1 cycle after s_valid, s_rdata0=0x0000_A5A5 -> m_rdata=0x0000_A5A5, m_ready at T+3, err_count=0.
REQ-045 Write, slave 2: m_addr=0x0500_0004, wstrb=4'b0011, wdata=0x1234_5678 -> s_valid=4'b0100, s_wstrb=4'b0011, s_addr=0x0500_0004, one m_ready pulse.
REQ-046 Decode error: m_addr=0x0900_0000 -> no s_valid, m_ready at T+2, m_rdata=0xDEAD_BEEF, err_irq pulse, err_count=1.
REQ-047 Timeout: TIMEOUT=8, slave 1 never ready -> s_valid[1] high 8 cycles, then m_rdata=0xDEAD_BEEF, err_count+1.
REQ-048 Boundary: s_ready asserted in the timeout cycle -> slave data returned, no err_irq; 300 decode errors -> err_count=0xFF.
REQ-049 Reset asserted mid-BUSY -> s_valid=0 next cycle, no m_ready, err_count=0; the following request completes normally.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared constants and state encoding for the CPU iomem switch.
package iomem_pkg;

  localparam int IOMEM_ADDR_W = 32;
  localparam int IOMEM_DATA_W = 32;
  localparam int IOMEM_STRB_W = 4;

  localparam logic [7:0]              IOMEM_BASE_ID  = 8'h03;
  localparam logic [IOMEM_DATA_W-1:0] IOMEM_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } iomem_state_e;

endpackage

// File: rtl/iomem_switch.sv
// Routes one CPU iomem request at a time to a slave selected by addr[31:24],
// with a per-request ready timeout and a saturating bus-error counter.
module iomem_switch
  import iomem_pkg::*;
#(
  parameter int         NUM_SLAVES = 4,
  parameter logic [7:0] BASE_ID    = IOMEM_BASE_ID,
  parameter int         TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           m_valid,
  output logic                           m_ready,
  input  logic [IOMEM_ADDR_W-1:0]        m_addr,
  input  logic [IOMEM_STRB_W-1:0]        m_wstrb,
  input  logic [IOMEM_DATA_W-1:0]        m_wdata,
  output logic [IOMEM_DATA_W-1:0]        m_rdata,
  output logic [NUM_SLAVES-1:0]          s_valid,
  output logic [IOMEM_ADDR_W-1:0]        s_addr,
  output logic [IOMEM_STRB_W-1:0]        s_wstrb,
  output logic [IOMEM_DATA_W-1:0]        s_wdata,
  input  logic [NUM_SLAVES-1:0]          s_ready,
  input  logic [32*NUM_SLAVES-1:0]       s_rdata,
  output logic [7:0]                     err_count,
  output logic                           err_irq,
  output logic [1:0]                     state_dbg
);

  // Handshake: the CPU holds m_valid until m_ready pulses for one cycle; the
  // request is captured in IDLE only. A slave sees its s_valid bit high until
  // it raises s_ready for one cycle or the wait counter expires.
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUSY = ST_BUSY;
  localparam logic [1:0] RESP = ST_RESP;
  localparam logic [1:0] ERR  = ST_ERR;

  logic [1:0]                state;
  logic [7:0]                sel;
  logic [7:0]                sel_q;
  logic                      sel_ok;
  logic [NUM_SLAVES-1:0]     sel_onehot;
  logic                      ready_hit;
  logic [IOMEM_DATA_W-1:0]   slave_data;
  logic [7:0]                wait_cnt;
  logic                      timed_out;

  // Addresses below BASE_ID wrap to large sel values and decode as errors.
  always_comb begin
    sel        = m_addr[31:24] - BASE_ID;
    sel_ok     = (sel < 8'(NUM_SLAVES));
    sel_onehot = '0;
    ready_hit  = 1'b0;
    slave_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == 8'(i)) sel_onehot[i] = 1'b1;
      if (sel_q == 8'(i)) begin
        ready_hit  = s_ready[i];
        slave_data = s_rdata[32*i +: 32];
      end
    end
    timed_out = (wait_cnt == 8'(TIMEOUT - 1));
  end

  assign m_ready   = (state == RESP);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wstrb   <= '0;
      s_wdata   <= '0;
      m_rdata   <= '0;
      wait_cnt  <= '0;
      err_count <= '0;
      err_irq   <= 1'b0;
    end else begin
      err_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            s_addr   <= m_addr;
            s_wstrb  <= m_wstrb;
            s_wdata  <= m_wdata;
            sel_q    <= sel;
            wait_cnt <= '0;
            if (sel_ok) begin
              s_valid <= sel_onehot;
              state   <= BUSY;
            end else begin
              state <= ERR;
            end
          end
        end
        BUSY: begin
          // A ready arriving in the timeout cycle still wins.
          if (ready_hit) begin
            m_rdata <= slave_data;
            s_valid <= '0;
            state   <= RESP;
          end else if (timed_out) begin
            m_rdata <= IOMEM_ERR_DATA;
            s_valid <= '0;
            err_irq <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR: begin
          m_rdata <= IOMEM_ERR_DATA;
          err_irq <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          state   <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_switch.sv
// Directed scoreboard bench for iomem_switch (4 slaves, TIMEOUT=8).
module tb_iomem_switch;

  localparam int NS = 4;
  localparam int W  = 41;  // {err_irq, err_count, m_rdata}

  logic          clk;
  logic          reset;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_addr;
  logic [3:0]    m_wstrb;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic [NS-1:0] s_valid;
  logic [31:0]   s_addr;
  logic [3:0]    s_wstrb;
  logic [31:0]   s_wdata;
  logic [NS-1:0] s_ready;
  logic [32*NS-1:0] s_rdata;
  logic [7:0]    err_count;
  logic          err_irq;
  logic [1:0]    state_dbg;

  iomem_switch #(
    .NUM_SLAVES(NS),
    .BASE_ID   (8'h03),
    .TIMEOUT   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_wstrb  (m_wstrb),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wstrb  (s_wstrb),
    .s_wdata  (s_wdata),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .err_count(err_count),
    .err_irq  (err_irq),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   model_err_cnt = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every m_ready pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_m_ready", 64'd1, 64'd0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("response", 64'({err_irq, err_count, m_rdata}), 64'(e));
        end
      end else if (err_irq) begin
        check("stray_err_irq", 64'(err_irq), 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  // delay = BUSY cycles before s_ready is raised (-1: never).
  task automatic run_req(input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int delay,
                         input logic [NS-1:0] noise, input logic [NS-1:0] exp_sv,
                         input int exp_lat, input logic [31:0] exp_rdata,
                         input logic exp_irq);
    int lat;
    int sv_cycles;
    bit seen;
    if (exp_irq && model_err_cnt != 8'hFF) model_err_cnt = model_err_cnt + 8'd1;
    exp_q.push_back({exp_irq, model_err_cnt, exp_rdata});
    m_valid = 1'b1;
    m_addr  = addr;
    m_wstrb = wstrb;
    m_wdata = wdata;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    m_addr  = 32'hFFFF_FFFF;
    m_wstrb = 4'hF;
    m_wdata = 32'hFFFF_FFFF;
    lat = 0;
    sv_cycles = 0;
    seen = 0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("s_valid", 64'(s_valid), 64'(exp_sv));
        check("s_addr", 64'(s_addr), 64'(addr));
        check("s_wstrb", 64'(s_wstrb), 64'(wstrb));
        check("s_wdata", 64'(s_wdata), 64'(wdata));
      end
      if (s_valid != '0) sv_cycles++;
      if (m_ready) begin
        seen = 1;
        lat  = k;
      end
      s_ready = (delay >= 0 && k == delay + 1) ? (exp_sv | noise) : noise;
    end
    s_ready = '0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("s_valid_cycles", 64'(sv_cycles), 64'((exp_sv != '0) ? exp_lat - 1 : 0));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wstrb = '0;
    m_wdata = '0;
    s_ready = '0;
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_A5A5};
    repeat (3) @(negedge clk);
    check("rst_m_ready", 64'(m_ready), 64'd0);
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_err_irq", 64'(err_irq), 64'd0);
    check("rst_s_bus", 64'({s_addr, s_wstrb, s_wdata}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // first request in the first cycle out of reset; slave 0 ready one cycle late
    reset = 1'b0;
    run_req(32'h0300_0000, 4'b0000, 32'h0, 1, 4'b0000, 4'b0001, 3, 32'h0000_A5A5, 1'b0);
    // write to slave 2 while the other slaves hold ready high
    run_req(32'h0500_0004, 4'b0011, 32'h1234_5678, 2, 4'b1011, 4'b0100, 4, 32'h2222_2222, 1'b0);
    // minimum latency on the last slave
    run_req(32'h0600_0010, 4'b1111, 32'hCAFE_F00D, 0, 4'b0000, 4'b1000, 2, 32'h3333_3333, 1'b0);
    // decode errors: above range and below base
    run_req(32'h0900_0000, 4'b0000, 32'h0, -1, 4'b0000, 4'b0000, 2, 32'hDEAD_BEEF, 1'b1);
    run_req(32'h0200_0000, 4'b0000, 32'h0, -1, 4'b0000, 4'b0000, 2, 32'hDEAD_BEEF, 1'b1);
    // timeout: slave 1 silent for all 8 cycles
    run_req(32'h0400_0000, 4'b0000, 32'h0, -1, 4'b0000, 4'b0010, 9, 32'hDEAD_BEEF, 1'b1);
    // ready arrives in the timeout cycle: slave wins
    run_req(32'h0400_0008, 4'b0000, 32'h0, 7, 4'b0000, 4'b0010, 9, 32'h1111_1111, 1'b0);
    check("err_count_after_timeout", 64'(err_count), 64'd3);

    // m_rdata holds while idle and while m_addr wiggles without m_valid
    m_addr = 32'h0300_0000;
    repeat (3) @(negedge clk);
    check("m_rdata_hold", 64'(m_rdata), 64'h1111_1111);
    check("idle_no_s_valid", 64'(s_valid), 64'd0);

    // saturation of the error counter
    for (int n = 0; n < 300; n++)
      run_req(32'h0900_0000 + 32'(n), 4'b0000, 32'h0, -1, 4'b0000, 4'b0000, 2, 32'hDEAD_BEEF, 1'b1);
    check("err_count_saturated", 64'(err_count), 64'hFF);

    // reset in the middle of a BUSY wait
    m_valid = 1'b1;
    m_addr  = 32'h0400_0000;
    m_wstrb = 4'b0000;
    m_wdata = 32'h0;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_reset", 64'(s_valid), 64'b0010);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_err_cnt = 8'd0;
    check("rst_busy_s_valid", 64'(s_valid), 64'd0);
    check("rst_busy_m_ready", 64'(m_ready), 64'd0);
    check("rst_busy_err_count", 64'(err_count), 64'd0);
    check("rst_busy_m_rdata", 64'(m_rdata), 64'd0);
    repeat (10) @(negedge clk);
    check("no_resp_after_reset", 64'(exp_q.size()), 64'd0);
    run_req(32'h0400_0000, 4'b0000, 32'h0, 7, 4'b0000, 4'b0010, 9, 32'h1111_1111, 1'b0);
    run_req(32'h0300_0000, 4'b0001, 32'h55, 0, 4'b0000, 4'b0001, 2, 32'h0000_A5A5, 1'b0);
    check("err_count_final", 64'(err_count), 64'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound in case the DUT wedges somewhere the driver cannot see.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "global timeout");
  end

endmodule
